// File: rtl/operand_normalizer.sv
// operand_normalizer: two-stage valid/ready pipeline that left-justifies an unsigned operand
// and reports the leading-zero count it shifted out.
module leading_zero_counter #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0]       i_value,
  output logic [$clog2(WIDTH):0] o_count
);
  // Scan upward so the highest set bit is the last to overwrite the count.
  always_comb begin
    o_count = ($clog2(WIDTH)+1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (i_value[i]) o_count = ($clog2(WIDTH)+1)'(WIDTH - 1 - i);
  end
endmodule

module operand_normalizer #(
  parameter int WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inputValid,
  output logic                   inputReady,
  input  logic [WIDTH-1:0]       operand,
  output logic                   outputValid,
  input  logic                   outputReady,
  output logic [WIDTH-1:0]       mantissa,
  output logic [$clog2(WIDTH):0] shift,
  output logic                   zero
);
  logic                   r_s1_v;
  logic                   r_s2_v;
  logic [WIDTH-1:0]       r_s1_op;
  logic [$clog2(WIDTH):0] r_s1_cnt;
  logic [$clog2(WIDTH):0] w_cnt;
  logic                   w_s2_adv;
  logic                   w_in_xfer;

  assign w_s2_adv    = !r_s2_v || outputReady;
  assign inputReady  = !r_s1_v || w_s2_adv;
  assign w_in_xfer   = inputValid && inputReady;
  assign outputValid = r_s2_v;

  leading_zero_counter #(.WIDTH(WIDTH)) u_lzc (
    .i_value(operand),
    .o_count(w_cnt)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s1_op  <= '0;
      r_s1_cnt <= '0;
      mantissa <= '0;
      shift    <= '0;
      zero     <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_v   <= 1'b1;
        r_s1_op  <= operand;
        r_s1_cnt <= w_cnt;
      end else if (w_s2_adv) begin
        r_s1_v <= 1'b0;
      end
      if (w_s2_adv) r_s2_v <= r_s1_v;
      // Data only moves into S2 with a valid S1 entry, so outputs hold otherwise.
      if (r_s1_v && w_s2_adv) begin
        mantissa <= r_s1_op << r_s1_cnt;
        shift    <= r_s1_cnt;
        zero     <= ~|r_s1_op;
      end
    end
  end
endmodule

// File: doc/operand_normalizer.md
OPERAND_NORMALIZER -- requirements
Module: operand_normalizer

Interface
REQ-001 SHALL have parameter WIDTH, default 24: operand/mantissa width in bits; legal range 1..64, power of 2 not required.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port inputValid, input, 1: operand offered this cycle.
REQ-005 SHALL have port inputReady, output, 1: block accepts operand this cycle.
REQ-006 SHALL have port operand, input, WIDTH: unsigned value to normalise.
REQ-007 SHALL have port outputValid, output, 1: result presented this cycle.
REQ-008 SHALL have port outputReady, input, 1: consumer takes result this cycle.
REQ-009 SHALL have port mantissa, output, WIDTH: operand shifted left until MSB set; all-zero if operand zero.
REQ-010 SHALL have port shift, output, $clog2(WIDTH)+1: leading-zero count applied; range 0..WIDTH.
REQ-011 SHALL have port zero, output, 1: high when operand was all-zero.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 registers operand plus leading-zero count from a LeadingZeroCounter instance (WIDTH-wide); S2 registers left-shifted mantissa, shift, zero.
REQ-013 SHALL transfer input when inputValid && inputReady at a rising edge; output when outputValid && outputReady.
REQ-014 SHALL have latency 2 cycles from input transfer to outputValid high with no backpressure.
REQ-015 SHALL sustain 1 transfer/cycle when outputReady held high.
REQ-016 SHALL drive inputReady = !s1Valid || s2Advance, where s2Advance = !s2Valid || outputReady (combinational, no input-to-output combinational path on data).
REQ-017 SHALL load S2 from S1 when s1Valid && s2Advance; S2 valid clears when output transfers and S1 empty.
REQ-018 SHALL hold mantissa, shift, zero stable while outputValid && !outputReady.
REQ-019 SHALL hold S1 contents while S1 valid and S2 stalled; no data loss or duplication.
REQ-020 SHALL compute mantissa = operand << count, truncated to WIDTH bits; mantissa[WIDTH-1] = 1 for any non-zero operand.
REQ-021 SHALL on zero operand output shift = WIDTH, mantissa = 0, zero = 1.
REQ-022 SHALL on operand with MSB set output shift = 0, mantissa = operand, zero = 0.
REQ-023 SHALL keep data outputs at last registered value when outputValid low (consumer ignores them).
REQ-024 SHALL preserve transfer order strictly (FIFO order, depth 2).
REQ-025 SHALL treat simultaneous input transfer and output transfer with both stages full as a legal shift-through (both stages advance same edge).

Reset
REQ-026 SHALL on reset_n low at a rising edge clear s1Valid, s2Valid, outputValid to 0; mantissa, shift, zero to 0.
REQ-027 SHALL drive inputReady = 1 from the first cycle after reset (both stages empty).
REQ-028 SHALL discard in-flight operands when reset asserted mid-operation; no output after reset release until a new input transfer.
REQ-029 SHALL ignore inputValid during reset cycles (no transfer recorded).

Verification
REQ-030 WIDTH=24, operand 0x000F00, outputReady=1 -> 2 cycles later outputValid=1, mantissa 0xF00000, shift 12, zero 0.
REQ-031 WIDTH=24, operand 0 -> mantissa 0, shift 24, zero 1; operand 0x800001 -> shift 0, mantissa 0x800001.
REQ-032 WIDTH=7, back-to-back operands 0x01, 0x40, 0x13 with outputReady=1 -> outputs on consecutive cycles: (0x40,6), (0x40,0), (0x4C,2).
REQ-033 outputReady=0 for 5 cycles while inputValid=1 -> exactly 2 operands accepted, inputReady low thereafter, outputs stable; release -> both delivered in order, then inputReady high.
REQ-034 reset_n low for 1 cycle with both stages full -> next cycle outputValid=0, inputReady=1; no stale result ever emitted.
REQ-035 Random stimulus, random outputReady, WIDTH in {1,2,5,8,24,32} -> scoreboard matches reference model (shift = leading-zero count, mantissa = operand<<shift) for every transfer, no drops.
